vlsu_load_packer: RTL and testbench
===================================

Name: vlsu_load_packer

Overview:
Read-side counterpart of the strided-store byte-enable generator in the vector load/store unit. Walks the same address sequence (base, byte stride, vl) and issues one word read per memory word touched. Extracts the addressed bytes from each returned 32-bit word and packs them contiguously, element 0 first, into a vector register image for writeback. Byte elements only.

Parameters:
VLEN_BYTES, 32, bytes in packed result; vl_i must be <= VLEN_BYTES.
IDX_W, 5, element index width, equal to $clog2(VLEN_BYTES).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  single-cycle launch; honoured only when busy_o = 0
base_addr_i  in  32  byte address of element 0
stride_i  in  32  byte stride, unsigned
vl_i  in  5  element count
req_valid_o  out  1  word read request valid
req_addr_o  out  32  word-aligned read address, bits [1:0] = 0
req_ready_i  in  1  memory accepts request
rvalid_i  in  1  read data valid; exactly one per accepted request, any latency >= 1
rdata_i  in  32  read data, byte k at bits [8k+7:8k]
vdata_o  out  8*VLEN_BYTES  packed result, element i at bits [8i+7:8i]
busy_o  out  1  operation in progress
done_o  out  1  one-cycle pulse when vdata_o is final

Behaviour:
- Reset: state IDLE; req_valid_o, busy_o, done_o = 0; req_addr_o, vdata_o, internal address, element pointer and remaining count = 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: start_i latches base_addr_i into cur_addr, stride_i, vl_i into remaining (6-bit), clears element pointer -> REQ; if vl_i = 0 -> DONE directly, no requests.
- REQ: req_valid_o = 1, req_addr_o = {cur_addr[31:2],2'b00}; held stable until req_ready_i, then -> WAIT. At most one request outstanding.
- WAIT: on rvalid_i, extract lanes (rules below), write bytes at pointer, pointer += n, remaining -= n, cur_addr <= next address; remaining becomes 0 -> DONE, else -> REQ.
- DONE: done_o = 1 for one cycle, -> IDLE. busy_o = 1 in REQ, WAIT and DONE.
- Lane selection per word; n never exceeds remaining:
  - stride 0: lane cur_addr[1:0]; byte replicated into all vl elements; n = vl; single request.
  - stride 1: lanes cur_addr[1:0] up to 3, truncated to remaining, written in ascending lane order; next = word base + 4.
  - stride >= 2: lane a = cur_addr[1:0]. If a + stride falls in the same word and remaining > 1, lane (a+stride)[1:0] is also taken (n = 2) and next = cur_addr + 2*stride; otherwise n = 1 and next = cur_addr + stride.
- Address arithmetic is modulo 2^32, wrap permitted.
- Minimum timing: start in cycle 0, req_valid_o in cycle 1; with zero-wait ready and rvalid in the following cycle, 2 cycles per word.
- start_i while busy_o = 1: ignored.
- rvalid_i outside WAIT: ignored.
- rst_i mid-operation: immediate abort to reset values. The bench discards any in-flight response.
- Elements >= vl: see Optional Feature.

Optional Feature:
PACKER_ZERO_TAIL_EN: when defined, accepting start_i clears vdata_o to 0, giving a zero tail for elements >= vl. When undefined, vdata_o bytes at index >= vl keep their prior values (tail undisturbed); only bytes < vl are written.

Decomposition:
- Package vlsu_pkg: state enum type, WORD_BYTES = 4, and a lane-select struct (lane mask, lane count, next address).
- Sub-module vlsu_lane_select: combinational; inputs cur_addr, stride, remaining; outputs lane mask, ordered lane list, n and next address. Shares its rules with the store-side enable logic.
- Packer FSM and vdata register stay in vlsu_load_packer.

Test Plan:
- stride 1, base 0x1002, vl 5; rdata 0x44332211 then 0x88776655 -> requests 0x1000, 0x1004; vdata_o[39:0] = 0x7766554433; done_o pulse after second rvalid.
- stride 2, base 0x2000, vl 3; rdata 0xDDCCBBAA, 0x11223344 -> requests 0x2000, 0x2004; vdata_o[23:0] = 0x44CCAA.
- stride 0, base 0x3001, vl 4, rdata 0xDDCCBBAA -> single request 0x3000; vdata_o[31:0] = 0xBBBBBBBB.
- stride 5, base 0x0, vl 3, req_ready_i delayed 3 cycles -> requests 0x0, 0x4, 0x8; req_addr_o stable while stalled; lanes 0, 1, 2.
- vl 0 -> no req_valid_o; done_o in cycle 2. start_i during busy -> ignored.
- rst_i asserted in WAIT -> next edge all outputs 0, state IDLE. Fresh start completes normally. Run tail check with and without PACKER_ZERO_TAIL_EN, tail preloaded to 0xFF.

Source files
------------

// File: rtl/vlsu_pkg.sv
// Shared types for the vector load/store unit: FSM state, lane-select result.
package vlsu_pkg;

  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  typedef struct packed {
    logic [WORD_BYTES-1:0] mask;
    logic [CNT_W-1:0]      cnt;
    logic [31:0]           next_addr;
  } lane_sel_t;

endpackage

// File: rtl/vlsu_load_packer_if.sv
// Control, memory-read and result signals of the load packer; master is the packer side.
interface vlsu_load_packer_if #(
  parameter int VLEN_BYTES = 32,
  parameter int IDX_W      = 5
);

  logic                    start_i;
  logic [31:0]             base_addr_i;
  logic [31:0]             stride_i;
  logic [IDX_W-1:0]        vl_i;
  logic                    req_valid_o;
  logic [31:0]             req_addr_o;
  logic                    req_ready_i;
  logic                    rvalid_i;
  logic [31:0]             rdata_i;
  logic [8*VLEN_BYTES-1:0] vdata_o;
  logic                    busy_o;
  logic                    done_o;

  modport master (
    input  start_i, base_addr_i, stride_i, vl_i, req_ready_i, rvalid_i, rdata_i,
    output req_valid_o, req_addr_o, vdata_o, busy_o, done_o
  );

  modport slave (
    output start_i, base_addr_i, stride_i, vl_i, req_ready_i, rvalid_i, rdata_i,
    input  req_valid_o, req_addr_o, vdata_o, busy_o, done_o
  );

endinterface

// File: rtl/vlsu_lane_select.sv
// Combinational lane picker for one memory word of a strided byte walk;
// the same rules drive the store-side byte-enable generator.
module vlsu_lane_select
  import vlsu_pkg::*;
(
  input  logic [31:0]                  i_cur_addr,
  input  logic [31:0]                  i_stride,
  input  logic [CNT_W-1:0]             i_remaining,
  output lane_sel_t                    o_sel,
  output logic [WORD_BYTES-1:0][1:0]   o_lanes
);

  logic [1:0] w_a;
  logic [2:0] w_avail;
  logic [2:0] w_pair_end;
  logic       w_pair;

  assign w_a        = i_cur_addr[1:0];
  assign w_avail    = 3'(WORD_BYTES) - {1'b0, w_a};
  assign w_pair_end = {1'b0, w_a} + {1'b0, i_stride[1:0]};
  // A second element shares the word only for strides 2..3 that stay below lane 4.
  assign w_pair     = (i_stride[31:2] == '0) && (w_pair_end < 3'(WORD_BYTES)) &&
                      (i_remaining > CNT_W'(1));

  always_comb begin
    o_sel   = '0;
    o_lanes = '0;
    if (i_stride == '0) begin
      o_sel.mask      = WORD_BYTES'(1) << w_a;
      o_sel.cnt       = i_remaining;
      o_sel.next_addr = i_cur_addr;
      for (int k = 0; k < WORD_BYTES; k++) o_lanes[k] = w_a;
    end else if (i_stride == 32'd1) begin
      o_sel.cnt       = (i_remaining < CNT_W'(w_avail)) ? i_remaining : CNT_W'(w_avail);
      o_sel.next_addr = {i_cur_addr[31:2], 2'b00} + 32'd4;
      for (int k = 0; k < WORD_BYTES; k++) begin
        o_lanes[k] = w_a + 2'(k);
        if ((3'(k) >= {1'b0, w_a}) && ((3'(k) - {1'b0, w_a}) < o_sel.cnt[2:0]))
          o_sel.mask[k] = 1'b1;
      end
    end else begin
      o_lanes[0] = w_a;
      if (w_pair) begin
        o_lanes[1]      = w_pair_end[1:0];
        o_sel.cnt       = CNT_W'(2);
        o_sel.mask      = (WORD_BYTES'(1) << w_a) | (WORD_BYTES'(1) << w_pair_end[1:0]);
        o_sel.next_addr = i_cur_addr + (i_stride << 1);
      end else begin
        o_sel.cnt       = CNT_W'(1);
        o_sel.mask      = WORD_BYTES'(1) << w_a;
        o_sel.next_addr = i_cur_addr + i_stride;
      end
    end
  end

endmodule

// File: rtl/vlsu_load_packer.sv
// Strided byte gather: one word read per touched word, bytes packed element 0 first.
// Define PACKER_ZERO_TAIL_EN to clear vdata_o on start (zero tail); default leaves the tail undisturbed.
module vlsu_load_packer
  import vlsu_pkg::*;
#(
  parameter int VLEN_BYTES = 32,
  parameter int IDX_W      = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  vlsu_load_packer_if.master bus
);

  localparam int PTR_W = IDX_W + 1;

  state_t                   r_state;
  logic [31:0]              r_cur_addr;
  logic [31:0]              r_stride;
  logic [CNT_W-1:0]         r_remaining;
  logic [PTR_W-1:0]         r_ptr;
  logic [8*VLEN_BYTES-1:0]  r_vdata;
  logic                     r_req_valid;
  logic [31:0]              r_req_addr;
  logic                     r_busy;
  logic                     r_done;

  lane_sel_t                   w_sel;
  logic [WORD_BYTES-1:0][1:0]  w_lanes;
  logic [8*VLEN_BYTES-1:0]     w_vdata_nxt;
  logic [1:0]                  w_lane;

  vlsu_lane_select u_lane_select (
    .i_cur_addr  (r_cur_addr),
    .i_stride    (r_stride),
    .i_remaining (r_remaining),
    .o_sel       (w_sel),
    .o_lanes     (w_lanes)
  );

  // Element ptr+j takes the byte from the j-th selected lane of the returned word.
  always_comb begin
    w_vdata_nxt = r_vdata;
    w_lane      = '0;
    for (int i = 0; i < VLEN_BYTES; i++) begin
      if ((i >= int'(r_ptr)) && ((i - int'(r_ptr)) < int'(w_sel.cnt))) begin
        w_lane = w_lanes[2'(i - int'(r_ptr))];
        if (w_sel.mask[w_lane])
          w_vdata_nxt[8*i +: 8] = bus.rdata_i[{w_lane, 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cur_addr  <= '0;
      r_stride    <= '0;
      r_remaining <= '0;
      r_ptr       <= '0;
      r_vdata     <= '0;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start_i) begin
            r_cur_addr  <= bus.base_addr_i;
            r_stride    <= bus.stride_i;
            r_remaining <= CNT_W'(bus.vl_i);
            r_ptr       <= '0;
            r_busy      <= 1'b1;
`ifdef PACKER_ZERO_TAIL_EN
            r_vdata     <= '0;
`endif
            if (bus.vl_i == '0) begin
              r_state <= DONE;
            end else begin
              r_state     <= REQ;
              r_req_valid <= 1'b1;
              r_req_addr  <= {bus.base_addr_i[31:2], 2'b00};
            end
          end
        end
        REQ: begin
          if (bus.req_ready_i) begin
            r_req_valid <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.rvalid_i) begin
            r_vdata     <= w_vdata_nxt;
            r_ptr       <= r_ptr + PTR_W'(w_sel.cnt);
            r_remaining <= r_remaining - w_sel.cnt;
            r_cur_addr  <= w_sel.next_addr;
            if (r_remaining == w_sel.cnt) begin
              r_state <= DONE;
            end else begin
              r_state     <= REQ;
              r_req_valid <= 1'b1;
              r_req_addr  <= {w_sel.next_addr[31:2], 2'b00};
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_valid_o = r_req_valid;
  assign bus.req_addr_o  = r_req_addr;
  assign bus.vdata_o     = r_vdata;
  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;

endmodule

// File: tb/tb_vlsu_load_packer.sv
// Scoreboard bench for vlsu_load_packer: byte-level memory model, queued expected requests and results.
module tb_vlsu_load_packer;

  localparam int VB = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vlsu_load_packer_if #(.VLEN_BYTES(VB), .IDX_W(5)) bus_if ();

  vlsu_load_packer #(.VLEN_BYTES(VB), .IDX_W(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int rst_gen = 0;
  int ready_mode = 0;

  logic [7:0]      mem [bit [31:0]];
  logic [31:0]     exp_addr_q [$];
  logic [8*VB-1:0] exp_vdata_q [$];
  logic [8*VB-1:0] shadow = '0;

  function automatic logic [7:0] mem_get(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  task automatic check(input string name, input logic [8*VB-1:0] act, input logic [8*VB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: element i lives at base + i*stride; one read per run of elements in the same word.
  task automatic push_op(input logic [31:0] base, input logic [31:0] stride, input int vl);
    logic [31:0]     a;
    logic [31:0]     w;
    logic [31:0]     last;
    logic [8*VB-1:0] v;
    v    = shadow;
    last = '0;
`ifdef PACKER_ZERO_TAIL_EN
    v = '0;
`endif
    for (int i = 0; i < vl; i++) begin
      a = base + 32'(i) * stride;
      v[8*i +: 8] = mem_get(a);
      w = {a[31:2], 2'b00};
      if (i == 0 || w != last) exp_addr_q.push_back(w);
      last = w;
    end
    exp_vdata_q.push_back(v);
    shadow = v;
  endtask

  task automatic do_reset();
    rst_gen++;
    rst = 1'b1;
    bus_if.rvalid_i = 1'b0;
    exp_addr_q.delete();
    exp_vdata_q.delete();
    shadow = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] base, input logic [31:0] stride, input int vl);
    int c;
    bit ok;
    c  = done_cnt;
    ok = 1'b0;
    push_op(base, stride, vl);
    bus_if.base_addr_i = base;
    bus_if.stride_i    = stride;
    bus_if.vl_i        = 5'(vl);
    bus_if.start_i     = 1'b1;
    @(posedge clk); #1;
    bus_if.start_i = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (done_cnt > c) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL done_timeout: base %h stride %h vl %0d got no done want done", base, stride, vl);
      do_reset();
    end
  endtask

  // Memory responder: one rvalid per accepted request, latency 1..3 cycles.
  initial begin
    bus_if.rvalid_i = 1'b0;
    bus_if.rdata_i  = '0;
    forever begin
      logic [31:0] a;
      int          lat;
      int          g;
      @(negedge clk);
      if (!rst && bus_if.req_valid_o && bus_if.req_ready_i) begin
        a   = bus_if.req_addr_o;
        g   = rst_gen;
        lat = $urandom_range(1, 3);
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1;
        if (g == rst_gen && !rst) begin
          bus_if.rdata_i  = {mem_get(a + 32'd3), mem_get(a + 32'd2), mem_get(a + 32'd1), mem_get(a)};
          bus_if.rvalid_i = 1'b1;
          @(posedge clk); #1;
          bus_if.rvalid_i = 1'b0;
        end
      end
    end
  end

  initial begin
    int stall_cnt;
    stall_cnt = 0;
    bus_if.req_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: bus_if.req_ready_i = 1'b1;
        1: begin
          if (bus_if.req_valid_o) begin
            if (stall_cnt >= 3) begin
              bus_if.req_ready_i = 1'b1;
              stall_cnt = 0;
            end else begin
              bus_if.req_ready_i = 1'b0;
              stall_cnt++;
            end
          end else begin
            bus_if.req_ready_i = 1'b0;
            stall_cnt = 0;
          end
        end
        default: bus_if.req_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Request monitor: address order and stability while stalled.
  initial begin
    logic        pv;
    logic [31:0] pa;
    pv = 1'b0;
    pa = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv) begin
          if (bus_if.req_valid_o) begin
            check("req_addr_stable", 256'(bus_if.req_addr_o), 256'(pa));
          end else begin
            n_cmp++; n_err++;
            $display("FAIL req_dropped: got valid 0 want valid 1 at addr %h", pa);
          end
        end
        if (bus_if.req_valid_o && bus_if.req_ready_i) begin
          if (exp_addr_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_req: got addr %h want no request", bus_if.req_addr_o);
          end else begin
            check("req_addr", 256'(bus_if.req_addr_o), 256'(exp_addr_q.pop_front()));
          end
          pv = 1'b0;
        end else begin
          pv = bus_if.req_valid_o;
          pa = bus_if.req_addr_o;
        end
      end
    end
  end

  // Result monitor: vdata_o on each done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus_if.done_o) begin
        done_cnt++;
        if (exp_vdata_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: got done want none");
        end else begin
          check("vdata", bus_if.vdata_o, exp_vdata_q.pop_front());
          check("reqs_pending_at_done", 256'(exp_addr_q.size()), 256'(0));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_tail;
    int         c;
    rst = 1'b1;
    bus_if.start_i     = 1'b0;
    bus_if.base_addr_i = '0;
    bus_if.stride_i    = '0;
    bus_if.vl_i        = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", 256'(bus_if.req_valid_o), 256'(0));
    check("rst_req_addr", 256'(bus_if.req_addr_o), 256'(0));
    check("rst_vdata", bus_if.vdata_o, '0);
    check("rst_busy", 256'(bus_if.busy_o), 256'(0));
    check("rst_done", 256'(bus_if.done_o), 256'(0));
    rst = 1'b0;

    // Stride 1 across a word boundary.
    {mem[32'h1003], mem[32'h1002], mem[32'h1001], mem[32'h1000]} = 32'h44332211;
    {mem[32'h1007], mem[32'h1006], mem[32'h1005], mem[32'h1004]} = 32'h88776655;
    run_op(32'h1002, 32'd1, 5);
    check("t1_vdata", 256'(bus_if.vdata_o[39:0]), 256'(40'h7766554433));

    // Stride 2 pairs lanes 0 and 2.
    {mem[32'h2003], mem[32'h2002], mem[32'h2001], mem[32'h2000]} = 32'hDDCCBBAA;
    {mem[32'h2007], mem[32'h2006], mem[32'h2005], mem[32'h2004]} = 32'h11223344;
    run_op(32'h2000, 32'd2, 3);
    check("t2_vdata", 256'(bus_if.vdata_o[23:0]), 256'(24'h44CCAA));

    // Stride 0 broadcast from one request.
    {mem[32'h3003], mem[32'h3002], mem[32'h3001], mem[32'h3000]} = 32'hDDCCBBAA;
    run_op(32'h3001, 32'd0, 4);
    check("t3_vdata", 256'(bus_if.vdata_o[31:0]), 256'(32'hBBBBBBBB));

    // Stride 5 with a 3-cycle ready stall per request.
    ready_mode = 1;
    run_op(32'h0, 32'd5, 3);
    check("t4_lanes", 256'(bus_if.vdata_o[23:0]), 256'({mem_get(32'd10), mem_get(32'd5), mem_get(32'd0)}));
    ready_mode = 0;

    // vl 0: no request, done in cycle 2; a start while busy is ignored.
    c = done_cnt;
    push_op(32'h4000, 32'd3, 0);
    bus_if.base_addr_i = 32'h4000;
    bus_if.stride_i    = 32'd3;
    bus_if.vl_i        = 5'd0;
    bus_if.start_i     = 1'b1;
    @(posedge clk); #1;
    check("vl0_c1_busy", 256'(bus_if.busy_o), 256'(1));
    check("vl0_c1_done", 256'(bus_if.done_o), 256'(0));
    check("vl0_c1_req", 256'(bus_if.req_valid_o), 256'(0));
    bus_if.base_addr_i = 32'h4400;
    bus_if.stride_i    = 32'd1;
    bus_if.vl_i        = 5'd7;
    @(posedge clk); #1;
    bus_if.start_i = 1'b0;
    check("vl0_c2_done", 256'(bus_if.done_o), 256'(1));
    check("vl0_c2_busy", 256'(bus_if.busy_o), 256'(0));
    check("vl0_c2_req", 256'(bus_if.req_valid_o), 256'(0));
    repeat (10) @(posedge clk);
    #1;
    check("busy_start_ignored", 256'(done_cnt), 256'(c + 1));

    // Reset while waiting for read data, then a fresh operation.
    push_op(32'h7000, 32'd1, 20);
    bus_if.base_addr_i = 32'h7000;
    bus_if.stride_i    = 32'd1;
    bus_if.vl_i        = 5'd20;
    bus_if.start_i     = 1'b1;
    @(posedge clk); #1;
    bus_if.start_i = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus_if.req_valid_o && bus_if.req_ready_i) break;
    end
    @(posedge clk); #2;
    rst_gen++;
    rst = 1'b1;
    @(posedge clk); #1;
    bus_if.rvalid_i = 1'b0;
    exp_addr_q.delete();
    exp_vdata_q.delete();
    shadow = '0;
    check("abort_req_valid", 256'(bus_if.req_valid_o), 256'(0));
    check("abort_req_addr", 256'(bus_if.req_addr_o), 256'(0));
    check("abort_vdata", bus_if.vdata_o, '0);
    check("abort_busy", 256'(bus_if.busy_o), 256'(0));
    check("abort_done", 256'(bus_if.done_o), 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(32'h7100, 32'd2, 9);

    // Tail behaviour after preloading 0xFF into elements 0..30.
    for (int k = 0; k < 31; k++) mem[32'h5000 + 32'(k)] = 8'hFF;
    run_op(32'h5000, 32'd1, 31);
    run_op(32'h6000, 32'd1, 3);
`ifdef PACKER_ZERO_TAIL_EN
    exp_tail = 8'h00;
`else
    exp_tail = 8'hFF;
`endif
    check("tail_byte3", 256'(bus_if.vdata_o[8*3 +: 8]), 256'(exp_tail));
    check("tail_byte30", 256'(bus_if.vdata_o[8*30 +: 8]), 256'(exp_tail));

    // Randomized operations.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] base;
      logic [31:0] stride;
      int          vl;
      ready_mode = $urandom_range(0, 2);
      base = $urandom;
      if ($urandom_range(0, 3) == 0) base = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      case ($urandom_range(0, 6))
        0: stride = 32'd0;
        1: stride = 32'd1;
        2: stride = 32'd2;
        3: stride = 32'd3;
        4: stride = 32'd4;
        5: stride = 32'd5;
        default: stride = $urandom_range(6, 32'h0FFF_FFFF);
      endcase
      vl = $urandom_range(0, 31);
      run_op(base, stride, vl);
    end
    ready_mode = 0;
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
